// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: fetches 16 words per 512-bit block, expands them
// to W[0..63] and streams each word to the compression rounds over valid/ready.
module sha256_msg_scheduler #(
  parameter int ADDR_W = 8,
  parameter int BLK_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BLK_W-1:0]  num_blocks,
  output logic              req_word,
  output logic [ADDR_W-1:0] word_address,
  input  logic [31:0]       word_data,
  input  logic              word_valid,
  output logic [31:0]       w_out,
  output logic              w_valid,
  output logic [5:0]        w_round,
  input  logic              w_ready,
  output logic              busy,
  output logic              block_done,
  output logic              all_done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXPAND, S_EMIT, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [5:0]        t_q, t_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [BLK_W-1:0]  nblk_q, nblk_d;
  logic [15:0][31:0] win_q, win_d;
  logic [31:0]       w_out_q, w_out_d;
  logic [5:0]        w_round_q, w_round_d;
  logic              w_valid_q, w_valid_d;
  logic              busy_q, busy_d;
  logic              block_done_q, block_done_d;
  logic              all_done_q, all_done_d;
  logic [31:0]       expand_w;
  logic [BLK_W+3:0]  addr_raw;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // win_q[15] is W[t-1] and win_q[0] is W[t-16] when W[t] is being computed.
  assign expand_w = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  assign addr_raw     = {blk_q, t_q[3:0]};
  assign word_address = ADDR_W'(addr_raw);
  assign w_out        = w_out_q;
  assign w_valid      = w_valid_q;
  assign w_round      = w_round_q;
  assign busy         = busy_q;
  assign block_done   = block_done_q;
  assign all_done     = all_done_q;

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    blk_d        = blk_q;
    nblk_d       = nblk_q;
    win_d        = win_q;
    w_out_d      = w_out_q;
    w_round_d    = w_round_q;
    w_valid_d    = w_valid_q;
    busy_d       = busy_q;
    block_done_d = 1'b0;
    all_done_d   = 1'b0;
    req_word     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nblk_d  = num_blocks;
          blk_d   = '0;
          t_d     = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        req_word = 1'b1;
        if (word_valid) begin
          w_out_d   = word_data;
          w_round_d = t_q;
          w_valid_d = 1'b1;
          state_d   = S_EMIT;
        end
      end
      S_EXPAND: begin
        w_out_d   = expand_w;
        w_round_d = t_q;
        w_valid_d = 1'b1;
        state_d   = S_EMIT;
      end
      S_EMIT: begin
        if (w_ready) begin
          win_d     = {w_out_q, win_q[15:1]};
          w_valid_d = 1'b0;
          if (t_q != 6'd63) begin
            t_d     = t_q + 6'd1;
            state_d = (t_q < 6'd15) ? S_FETCH : S_EXPAND;
          end else begin
            block_done_d = 1'b1;
            if (blk_q != nblk_q) begin
              blk_d   = blk_q + 1'b1;
              t_d     = '0;
              state_d = S_FETCH;
            end else begin
              state_d = S_FINISH;
            end
          end
        end
      end
      S_FINISH: begin
        all_done_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      blk_q        <= '0;
      nblk_q       <= '0;
      win_q        <= '0;
      w_out_q      <= '0;
      w_round_q    <= '0;
      w_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
      all_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      blk_q        <= blk_d;
      nblk_q       <= nblk_d;
      win_q        <= win_d;
      w_out_q      <= w_out_d;
      w_round_q    <= w_round_d;
      w_valid_q    <= w_valid_d;
      busy_q       <= busy_d;
      block_done_q <= block_done_d;
      all_done_q   <= all_done_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Bench for sha256_msg_scheduler: a word memory acts as the message controller;
// accepted schedule words are captured and compared to constants and a reference schedule.
module tb_sha256_msg_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, w_ready, stall;
  logic [3:0]  num_blocks;
  logic        req_word, word_valid, w_valid, busy, block_done, all_done;
  logic [7:0]  word_address;
  logic [31:0] word_data, w_out;
  logic [5:0]  w_round;

  logic [31:0] mem [256];
  logic [31:0] gold [16][64];
  logic [31:0] cap  [16][64];
  int          addr_log [$];

  int errors = 0, checks = 0;
  int nbd, nad, stall_left, bp_left, bp_rnd, start_rnd, rst_rnd;
  bit aborted, seq_bad, stall_bad, hold_bad, busy_at_done;
  logic [7:0]  stall_addr;
  logic [63:0] rst_snap;

  typedef struct {
    string       name;
    int          rnd;
    logic [31:0] exp;
  } vec_t;
  vec_t abc_vec [6];

  always #5 clk = ~clk;

  assign word_valid = req_word & ~stall;
  assign word_data  = mem[word_address];

  sha256_msg_scheduler #(.ADDR_W(8), .BLK_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
    .req_word(req_word), .word_address(word_address), .word_data(word_data),
    .word_valid(word_valid), .w_out(w_out), .w_valid(w_valid), .w_round(w_round),
    .w_ready(w_ready), .busy(busy), .block_done(block_done), .all_done(all_done)
  );

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sched_errs(input int b);
    int m = 0;
    for (int r = 0; r < 64; r++) if (cap[b][r] !== gold[b][r]) m++;
    return m;
  endfunction

  function automatic bit addr_ok(input int n);
    if (addr_log.size() != n) return 1'b0;
    for (int i = 0; i < n; i++) if (addr_log[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_scen();
    stall_left = 0; stall_addr = 8'd0; bp_left = 0; bp_rnd = -1;
    start_rnd = -1; rst_rnd = -1;
  endtask

  // Starts a message and plays the controller / round side until all_done,
  // a mid-run reset, or the cycle budget runs out.
  task automatic run(input logic [3:0] nb, input int budget);
    bit          fin, hold_set;
    logic [31:0] hold_w;
    int          exp_rnd;
    nbd = 0; nad = 0; aborted = 0; seq_bad = 0; stall_bad = 0; hold_bad = 0;
    busy_at_done = 1'b1; addr_log.delete();
    for (int b = 0; b < 16; b++) for (int r = 0; r < 64; r++) cap[b][r] = 32'hDEADBEEF;
    exp_rnd = 0; fin = 0; hold_set = 0; hold_w = '0;
    num_blocks = nb; start = 1'b1; w_ready = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; num_blocks = ~nb;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      if (rst) begin
        rst_snap = {13'd0, req_word, word_address, w_out, w_valid, w_round, busy, block_done, all_done};
        rst = 1'b0; aborted = 1; fin = 1;
      end else begin
        if (block_done) nbd++;
        if (all_done) begin
          nad++; busy_at_done = busy; fin = 1;
        end else begin
          stall = 1'b0; w_ready = 1'b1; start = 1'b0;
          if (req_word && stall_left > 0 && word_address == stall_addr) begin
            stall = 1'b1; stall_left--;
            if (w_valid) stall_bad = 1;
          end
          if (w_valid && int'(w_round) == bp_rnd && bp_left > 0) begin
            if (!hold_set) begin hold_w = w_out; hold_set = 1; end
            else if (w_out !== hold_w) hold_bad = 1;
            w_ready = 1'b0; bp_left--;
          end
          if (w_valid && int'(w_round) == start_rnd) begin
            start = 1'b1; num_blocks = 4'd3; start_rnd = -1;
          end
          if (w_valid && int'(w_round) == rst_rnd) begin
            rst = 1'b1; rst_rnd = -1;
          end
          if (!rst && w_valid && w_ready) begin
            if (int'(w_round) != exp_rnd) seq_bad = 1;
            if (nbd < 16) cap[nbd][w_round] = w_out;
            exp_rnd = (exp_rnd + 1) % 64;
          end
          if (!rst && req_word && !stall) addr_log.push_back(int'(word_address));
          @(posedge clk); #1;
        end
      end
    end
    chk("run_terminates", {63'd0, fin}, 64'd1);
    start = 1'b0; stall = 1'b0; w_ready = 1'b1;
  endtask

  initial begin
    abc_vec[0] = '{"abc_W0",  0,  32'h61626380};
    abc_vec[1] = '{"abc_W15", 15, 32'h00000018};
    abc_vec[2] = '{"abc_W16", 16, 32'h61626380};
    abc_vec[3] = '{"abc_W17", 17, 32'h000F0000};
    abc_vec[4] = '{"abc_W18", 18, 32'h7DA86405};
    abc_vec[5] = '{"abc_W63", 63, 32'h12B1EDEB};

    for (int i = 0; i < 256; i++) mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A00FF;
    mem[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) mem[i] = 32'h0;
    mem[15] = 32'h00000018;
    for (int b = 0; b < 16; b++) begin
      for (int t = 0; t < 16; t++) gold[b][t] = mem[b*16 + t];
      for (int t = 16; t < 64; t++)
        gold[b][t] = ss1(gold[b][t-2]) + gold[b][t-7] + ss0(gold[b][t-15]) + gold[b][t-16];
    end

    rst = 1'b1; start = 1'b0; num_blocks = 4'd0; w_ready = 1'b1; stall = 1'b0;
    clear_scen();
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs",
        {13'd0, req_word, word_address, w_out, w_valid, w_round, busy, block_done, all_done}, 64'd0);
    rst = 1'b0;

    // Single "abc" block
    run(4'd0, 300);
    for (int i = 0; i < 6; i++) chk(abc_vec[i].name, cap[0][abc_vec[i].rnd], abc_vec[i].exp);
    chk("abc_block_done_cnt", nbd, 1);
    chk("abc_all_done_cnt", nad, 1);
    chk("abc_busy_low", busy_at_done, 0);
    chk("abc_addr_seq", addr_ok(16), 1);
    chk("abc_schedule", sched_errs(0), 0);
    chk("abc_round_order", seq_bad, 0);
    @(posedge clk); #1;
    chk("abc_idle_busy", busy, 0);

    // Two blocks: addresses continue into block 1, w_round wraps 63 -> 0
    run(4'd1, 600);
    chk("two_block_done_cnt", nbd, 2);
    chk("two_all_done_cnt", nad, 1);
    chk("two_addr_seq", addr_ok(32), 1);
    chk("two_sched_b0", sched_errs(0), 0);
    chk("two_sched_b1", sched_errs(1), 0);
    chk("two_round_wrap", seq_bad, 0);

    // word_valid low for 5 cycles while word 3 is requested
    clear_scen(); stall_addr = 8'd3; stall_left = 5;
    run(4'd0, 300);
    chk("stall_consumed", stall_left, 0);
    chk("stall_no_w_valid", stall_bad, 0);
    chk("stall_addr_seq", addr_ok(16), 1);
    chk("stall_schedule", sched_errs(0), 0);

    // w_ready low for 4 cycles while W20 is presented
    clear_scen(); bp_rnd = 20; bp_left = 4;
    run(4'd0, 300);
    chk("bp_consumed", bp_left, 0);
    chk("bp_w_out_held", hold_bad, 0);
    chk("bp_W20", cap[0][20], gold[0][20]);
    chk("bp_W21", cap[0][21], gold[0][21]);
    chk("bp_round_order", seq_bad, 0);
    chk("bp_schedule", sched_errs(0), 0);

    // start (with num_blocks=3) pulsed while busy at t=10 is ignored
    clear_scen(); start_rnd = 10;
    run(4'd0, 300);
    chk("busy_start_block_done_cnt", nbd, 1);
    chk("busy_start_all_done_cnt", nad, 1);
    chk("busy_start_schedule", sched_errs(0), 0);

    // Reset at t=40, then a clean restart
    clear_scen(); rst_rnd = 40;
    run(4'd0, 300);
    chk("rst_aborted", aborted, 1);
    chk("rst_outputs_zero", rst_snap, 64'd0);
    chk("rst_no_done", nbd + nad, 0);
    repeat (3) @(posedge clk); #1;
    chk("rst_stays_idle", {62'd0, req_word, busy}, 64'd0);
    clear_scen();
    run(4'd0, 300);
    chk("restart_addr_seq", addr_ok(16), 1);
    chk("restart_schedule", sched_errs(0), 0);
    chk("restart_all_done_cnt", nad, 1);

    // num_blocks=15: sixteen blocks, addresses 0..255
    begin
      int m = 0;
      run(4'd15, 4000);
      for (int b = 0; b < 16; b++) m += sched_errs(b);
      chk("max_block_done_cnt", nbd, 16);
      chk("max_all_done_cnt", nad, 1);
      chk("max_addr_seq", addr_ok(256), 1);
      chk("max_schedule", m, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
